// File: rtl/operand_loader_pkg.sv
// Shared types and constants for the operand loader.
package operand_loader_pkg;

    localparam int DATA_W = 8;
    localparam int RES_W  = 9;

    // Operand index presented to the core on op
    localparam logic [1:0] OP_A = 2'b00;
    localparam logic [1:0] OP_B = 2'b01;
    localparam logic [1:0] OP_C = 2'b10;
    localparam logic [1:0] OP_D = 2'b11;

    typedef enum logic [1:0] {
        ST_CLR,
        ST_LOAD,
        ST_WAIT,
        ST_HOLD
    } state_t;

endpackage

// File: rtl/operand_loader_if.sv
// Host and core signal bundle for the operand loader.
// slave: the loader's view. master: the host/core side driving it.
interface operand_loader_if;
    import operand_loader_pkg::*;

    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;

    logic              core_reset;
    logic              capture;
    logic [1:0]        op;
    logic [DATA_W-1:0] d_in;
    logic              core_valid;
    logic [RES_W-1:0]  core_result;

    logic              out_valid;
    logic              out_ready;
    logic [RES_W-1:0]  out_result;
    logic              out_err;

    modport slave (
        input  in_valid, in_data, core_valid, core_result, out_ready,
        output in_ready, core_reset, capture, op, d_in,
               out_valid, out_result, out_err
    );

    modport master (
        output in_valid, in_data, core_valid, core_result, out_ready,
        input  in_ready, core_reset, capture, op, d_in,
               out_valid, out_result, out_err
    );

endinterface

// File: rtl/loader_timeout.sv
// WAIT-state cycle counter for the operand loader.
// Present only when LOADER_TIMEOUT_EN is defined; expired rises in the
// TIMEOUT-th consecutive cycle that run is held high.
`ifdef LOADER_TIMEOUT_EN
module loader_timeout #(
    parameter int TIMEOUT = 64
) (
    input  logic clock,
    input  logic reset,
    input  logic run,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] cnt;

    assign expired = run && (cnt == CNT_W'(TIMEOUT - 1));

    // Count cycles spent in WAIT; restart from zero whenever WAIT is left
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            cnt <= '0;
        else if (!run)
            cnt <= '0;
        else if (!expired)
            cnt <= cnt + CNT_W'(1);
    end

endmodule
`endif

// File: rtl/operand_loader.sv
// Operand loader: clears the core, streams host bytes A..D into it,
// waits for the core result and hands it back to the host.
// Optional: LOADER_TIMEOUT_EN adds a WAIT timeout that returns an error result.
module operand_loader
    import operand_loader_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic clock,
    input  logic reset,
    operand_loader_if.slave bus
);

    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("operand_loader: TIMEOUT must be at least 2");
    end

    state_t            state, state_nxt;
    logic [1:0]        idx;
    logic              accept;
    logic              core_hit;
    logic              wait_done;
    logic              capture_q;
    logic [1:0]        op_q;
    logic [DATA_W-1:0] d_in_q;
    logic              out_valid_q;
    logic [RES_W-1:0]  out_result_q;

    assign bus.in_ready   = (state == ST_LOAD);
    assign bus.core_reset = (state != ST_CLR);
    assign bus.capture    = capture_q;
    assign bus.op         = op_q;
    assign bus.d_in       = d_in_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_result = out_result_q;

    assign accept = (state == ST_LOAD) && bus.in_valid;
    // capture is high only in the first WAIT cycle, which doubles as the
    // marker for the cycle in which core_valid must be ignored
    assign core_hit = (state == ST_WAIT) && !capture_q && bus.core_valid;

`ifdef LOADER_TIMEOUT_EN
    logic timeout_hit;
    logic out_err_q;

    loader_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clock   (clock),
        .reset   (reset),
        .run     (state == ST_WAIT),
        .expired (timeout_hit)
    );

    assign wait_done   = core_hit || timeout_hit;
    assign bus.out_err = out_err_q;
`else
    assign wait_done   = core_hit;
    assign bus.out_err = 1'b0;
`endif

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            state <= ST_CLR;
        else
            state <= state_nxt;
    end

    // Next-state decode
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_CLR:  state_nxt = ST_LOAD;
            ST_LOAD: if (accept && idx == OP_D) state_nxt = ST_WAIT;
            ST_WAIT: if (wait_done) state_nxt = ST_HOLD;
            ST_HOLD: if (bus.out_ready) state_nxt = ST_CLR;
            default: state_nxt = ST_CLR;
        endcase
    end

    // Present each accepted byte to the core in the cycle after the handshake
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            capture_q <= 1'b0;
            op_q      <= OP_A;
            d_in_q    <= '0;
            idx       <= OP_A;
        end else begin
            capture_q <= accept;
            if (state == ST_CLR)
                idx <= OP_A;
            if (accept) begin
                op_q   <= idx;
                d_in_q <= bus.in_data;
                // idx only returns to A through CLR
                if (idx != OP_D)
                    idx <= idx + 2'd1;
            end
        end
    end

    // Latch the result on leaving WAIT and hold it until the host takes it
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
`ifdef LOADER_TIMEOUT_EN
            out_err_q    <= 1'b0;
`endif
        end else if (core_hit) begin
            out_valid_q  <= 1'b1;
            out_result_q <= bus.core_result;
`ifdef LOADER_TIMEOUT_EN
            out_err_q    <= 1'b0;
        end else if (timeout_hit) begin
            out_valid_q  <= 1'b1;
            out_result_q <= '0;
            out_err_q    <= 1'b1;
`endif
        end else if (state == ST_HOLD && bus.out_ready) begin
            out_valid_q  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_operand_loader.sv
// Self-checking bench for operand_loader. Expected core loads and results
// are queued as stimulus is driven and popped as the DUT produces them.
module tb_operand_loader;
    import operand_loader_pkg::*;

`ifdef LOADER_TIMEOUT_EN
    localparam int TMO = 8;
`else
    localparam int TMO = 64;
`endif

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   cyc   = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    operand_loader_if bus();

    operand_loader #(.TIMEOUT(TMO)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int         vec_cnt  = 0;
    int         miss_cnt = 0;
    logic [9:0] cap_q[$];
    logic [9:0] res_q[$];
    logic [9:0] cap_e;
    int         cap_run  = 0;
    int         last_run = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Core-side monitor: every capture strobe must match the next queued load
    always @(negedge clock) begin
        if (bus.capture === 1'b1) begin
            cap_run++;
            if (cap_q.size() == 0)
                chk("cap_unexpected", {31'b0, bus.capture}, 32'd0);
            else begin
                cap_e = cap_q.pop_front();
                chk("cap_op_d", {22'b0, bus.op, bus.d_in}, {22'b0, cap_e});
            end
        end else begin
            if (cap_run != 0) last_run = cap_run;
            cap_run = 0;
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge
    task automatic send_byte(input logic [7:0] b, input logic [1:0] op_exp);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        while (!bus.in_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        chk("accept", {31'b0, bus.in_ready}, 32'd1);
        cap_q.push_back({op_exp, b});
        @(negedge clock);
    endtask

    // One full frame, entered at the negedge of a CLR cycle and left at the
    // negedge of the following CLR cycle. cv_delay < 0: core never answers.
    task automatic frame(input logic [3:0][7:0] b, input int gap, input bit wait_ign,
                         input int cv_delay, input int hold, input int exp_lat);
        logic [8:0] res;
        logic [9:0] e;
        int         n;
        int         t0;
        res = 9'(b[0]) + 9'(b[1]) + 9'(b[2]) + 9'(b[3]);
        t0  = cyc;
        chk("clr_core_reset", {31'b0, bus.core_reset}, 32'd0);
        chk("clr_in_ready", {31'b0, bus.in_ready}, 32'd0);
        res_q.push_back(cv_delay < 0 ? 10'h200 : {1'b0, res});
        for (int i = 0; i < 4; i++) begin
            send_byte(b[i], 2'(i));
            if (i == 0 && gap > 0) begin
                bus.in_valid = 1'b0;
                repeat (gap) begin
                    @(negedge clock);
                    chk("gap_capture", {31'b0, bus.capture}, 32'd0);
                    chk("gap_op", {30'b0, bus.op}, {30'b0, OP_A});
                end
            end
        end
        // now in the first WAIT cycle; a stray host byte must not be taken
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hAA;
        chk("wait_in_ready", {31'b0, bus.in_ready}, 32'd0);
        chk("wait_core_reset", {31'b0, bus.core_reset}, 32'd1);
        if (wait_ign) begin
            bus.core_valid  = 1'b1;
            bus.core_result = 9'h0AB;
            @(negedge clock);
            bus.core_valid = 1'b0;
            chk("wait1_ignored", {31'b0, bus.out_valid}, 32'd0);
        end
        n = 0;
        if (cv_delay >= 0) begin
            repeat (cv_delay) begin
                @(negedge clock);
                chk("wait_no_out", {31'b0, bus.out_valid}, 32'd0);
            end
            bus.core_valid  = 1'b1;
            bus.core_result = res;
        end
        while (!bus.out_valid && n < TMO + 20) begin
            @(negedge clock);
            n++;
        end
        bus.core_valid  = 1'b0;
        bus.core_result = 9'h155;
        chk("out_valid", {31'b0, bus.out_valid}, 32'd1);
        if (exp_lat > 0) chk("frame_latency", cyc - t0, exp_lat);
        if (cv_delay < 0 && !wait_ign) chk("timeout_cycles", n, TMO);
        e = res_q.pop_front();
        chk("out_result", {23'b0, bus.out_result}, {23'b0, e[8:0]});
        chk("out_err", {31'b0, bus.out_err}, {31'b0, e[9]});
        repeat (hold) begin
            @(negedge clock);
            chk("hold_valid", {31'b0, bus.out_valid}, 32'd1);
            chk("hold_result", {23'b0, bus.out_result}, {23'b0, e[8:0]});
            chk("hold_in_ready", {31'b0, bus.in_ready}, 32'd0);
        end
        bus.out_ready = 1'b1;
        @(negedge clock);
        bus.out_ready = 1'b0;
        chk("ack_out_valid", {31'b0, bus.out_valid}, 32'd0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"}, {31'b0, bus.in_ready}, 32'd0);
        chk({tag, "_core_reset"}, {31'b0, bus.core_reset}, 32'd0);
        chk({tag, "_capture"}, {31'b0, bus.capture}, 32'd0);
        chk({tag, "_op"}, {30'b0, bus.op}, 32'd0);
        chk({tag, "_d_in"}, {24'b0, bus.d_in}, 32'd0);
        chk({tag, "_out_valid"}, {31'b0, bus.out_valid}, 32'd0);
        chk({tag, "_out_result"}, {23'b0, bus.out_result}, 32'd0);
        chk({tag, "_out_err"}, {31'b0, bus.out_err}, 32'd0);
    endtask

    initial begin
        logic [3:0][7:0] rb;
        bus.in_valid    = 1'b0;
        bus.in_data     = '0;
        bus.out_ready   = 1'b0;
        bus.core_valid  = 1'b0;
        bus.core_result = '0;
        repeat (3) @(negedge clock);
        chk_reset_vals("rst");
        reset = 1'b1;

        // back-to-back load, immediate core answer and host ack: 8-cycle frame
        frame({8'h00, 8'h00, 8'hFF, 8'hFF}, 0, 1'b0, 0, 0, 7);
        chk("b2b_capture_run", last_run, 4);

        // host stall after byte 1, WAIT1 core_valid ignored, output backpressure
        frame({8'h00, 8'h00, 8'h00, 8'h01}, 3, 1'b1, 2, 5, 0);

        // random bytes with a slow core
        rb = {8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
`ifdef LOADER_TIMEOUT_EN
        frame(rb, 0, 1'b0, 5, 1, 0);
        frame({8'h12, 8'h34, 8'h56, 8'h78}, 0, 1'b0, -1, 2, 0);
        // core_valid lands on the expiry cycle and must win
        frame({8'h80, 8'h80, 8'h80, 8'h80}, 0, 1'b0, TMO - 1, 0, 0);
`else
        frame(rb, 0, 1'b0, 20, 1, 0);
`endif

        // reset after byte 2 of a frame
        send_byte(8'h11, OP_A);
        send_byte(8'h22, OP_B);
        #2 reset = 1'b0;
        #1 chk_reset_vals("midrst");
        bus.in_valid = 1'b0;
        chk("midrst_cap_q", cap_q.size(), 0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        frame({8'h01, 8'h02, 8'h03, 8'hFE}, 0, 1'b0, 0, 0, 7);

        bus.in_valid = 1'b0;
        repeat (2) @(negedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
